// File: rtl/cpu_lsu_ctrl.sv
// cpu_lsu_ctrl: load/store unit bus controller.
// Accepts one core access at a time, lane-aligns store data and strobes,
// runs one (or two, when split) word beats on the memory bus, and returns
// sign/zero-extended load data with a one-cycle completion pulse.
// A beat that waits TIMEOUT_CYCLES cycles for mem_ready is abandoned with an error.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN -- when defined, misaligned
// accesses are split into two word beats instead of being rejected.
module cpu_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  // Reserved encodings, and stores asking for an unsigned (load-only) size.
  function automatic logic is_invalid(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  // Halfwords crossing the word boundary, or words not on a word boundary.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && (off == 2'b11)) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  // Byte strobes over two consecutive words; upper nibble belongs to the second beat.
  function automatic logic [7:0] lane_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'b0000_0001;
      2'b01:   base = 8'b0000_0011;
      default: base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

  // Store data shifted into its byte lanes over two consecutive words.
  function automatic logic [63:0] lane_data(input logic [31:0] wd, input logic [1:0] off);
    return {32'b0, wd} << {off, 3'b000};
  endfunction

  // Right-align the addressed field of a two-word window.
  function automatic logic [31:0] load_field(input logic [63:0] win, input logic [1:0] off);
    return 32'(win >> {off, 3'b000});
  endfunction

  // Sign or zero extension according to the access size.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] f);
    case (f3)
      3'b000:  return {{24{f[7]}}, f[7:0]};
      3'b001:  return {{16{f[15]}}, f[15:0]};
      3'b100:  return {24'b0, f[7:0]};
      3'b101:  return {16'b0, f[15:0]};
      default: return f;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q;
  logic        split_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [7:0]  strb_q;
  logic [63:0] wdat_q;
  logic [31:0] lo_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        done;
  logic        timeout;
  logic        req_bad;
  logic        req_split;
  logic [63:0] rd_win;

  assign req_split = SPLIT_EN && is_misaligned(req_funct3, req_addr[1:0]) &&
                     !is_invalid(req_we, req_funct3);
  assign req_bad   = is_invalid(req_we, req_funct3) ||
                     (!SPLIT_EN && is_misaligned(req_funct3, req_addr[1:0]));
  assign rd_win    = (state_q == BEAT1) ? {mem_rdata, lo_q} : {32'b0, mem_rdata};

  // Next-state, wait counter and handshake decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = 16'd0;
          state_d = req_bad ? RESP : BEAT0;
        end
      end
      BEAT0, BEAT1: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          cnt_d = 16'd0;
          if ((state_q == BEAT0) && split_q) begin
            state_d = BEAT1;
          end else begin
            state_d = RESP;
            done    = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, wait counter, error flag and split flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q   <= req_bad;
        split_q <= req_split;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Datapath: latched request, first-beat read word and response data.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= {req_addr[31:2], 2'b00};
      off_q   <= req_addr[1:0];
      strb_q  <= lane_strb(req_funct3, req_addr[1:0]);
      wdat_q  <= lane_data(req_wdata, req_addr[1:0]);
      rdata_q <= 32'd0;
    end else begin
      if ((state_q == BEAT0) && mem_ready) lo_q <= mem_rdata;
      if (done) rdata_q <= we_q ? 32'd0 : load_extend(f3_q, load_field(rd_win, off_q));
      if (timeout) rdata_q <= 32'd0;
    end
  end

  assign mem_we    = mem_valid && we_q;
  assign mem_addr  = (state_q == BEAT1) ? addr_q + 32'd4 : addr_q;
  assign mem_wstrb = mem_we ? ((state_q == BEAT1) ? strb_q[7:4] : strb_q[3:0]) : 4'b0000;
  assign mem_wdata = mem_we ? ((state_q == BEAT1) ? wdat_q[63:32] : wdat_q[31:0]) : 32'd0;

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: doc/cpu_lsu_ctrl.md
CPU_LSU_CTRL -- requirements
Module: cpu_lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles one bus beat may wait for mem_ready (range 1..65535).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  core access request.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-011 rsp_rdata  out  32  extended load data.
REQ-012 rsp_err  out  1  access failed; qualified by rsp_valid.
REQ-013 mem_valid  out  1  bus beat request.
REQ-014 mem_ready  in  1  bus beat complete.
REQ-015 mem_we  out  1  beat is a write.
REQ-016 mem_addr  out  32  word-aligned address, bits [1:0] = 00.
REQ-017 mem_wdata  out  32  lane-aligned write data.
REQ-018 mem_wstrb  out  4  byte-lane write enables; 0000 on reads.
REQ-019 mem_rdata  in  32  read data, valid when mem_valid && mem_ready.

Function
REQ-020 FSM SHALL have states IDLE, BEAT0, BEAT1, RESP; req_ready = 1 only in IDLE.
REQ-021 On accept: latch request; if invalid or misaligned-error -> RESP, else -> BEAT0.
REQ-022 Invalid: funct3 011/110/111, or store with funct3[2] = 1; no bus beat, rsp_err = 1.
REQ-023 Misaligned: H/HU with addr[1:0] = 11, W with addr[1:0] != 00.
REQ-024 BEAT0/BEAT1: mem_valid = 1; mem_* SHALL hold stable until mem_ready.
REQ-025 BEAT0 address {addr[31:2],00}; BEAT1 address BEAT0 + 4 (wraps modulo 2^32).
REQ-026 Store lanes: off = addr[1:0]; wstrb SB 0001<<off, SH 0011<<off, SW 1111; wdata = req_wdata << 8*off.
REQ-027 Load: field = read word >> 8*off, then B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-028 Beat complete with mem_ready -> BEAT1 if split pending, else RESP.
REQ-029 RESP lasts one cycle, drives rsp_valid = 1, then IDLE.
REQ-030 Latency, aligned access, mem_ready immediate: accept N, mem_valid N+1, rsp_valid N+2.
REQ-031 Error at accept: rsp_valid at N+1.
REQ-032 rsp_rdata = 0 for stores and errors; outputs hold 0 when rsp_valid = 0.
REQ-033 Per-beat wait counter clears on entering a beat; increments each cycle of mem_valid && !mem_ready.
REQ-034 Counter reaches TIMEOUT_CYCLES-1 with mem_ready low -> drop mem_valid, RESP with rsp_err = 1, skip BEAT1.
REQ-035 Back-to-back: the cycle after RESP is IDLE, so a new request accepts at earliest RESP+1.

Reset
REQ-036 rst SHALL force IDLE, counter 0, mem_valid 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 on the next edge.
REQ-037 Reset mid-transaction SHALL discard the access with no rsp_valid pulse.

Configuration
REQ-038 Macro LSU_MISALIGNED_SPLIT_EN defined: misaligned loads/stores split into BEAT0 (lanes off..3) and BEAT1 (remaining low lanes).
REQ-039 Split load: field = {BEAT1 rdata, BEAT0 rdata} >> 8*off, then extended per REQ-027.
REQ-040 Split store: BEAT1 wdata/wstrb = upper bytes of the 64-bit shifted data/strobe.
REQ-041 Macro undefined: misaligned access -> error per REQ-021, no bus beat.

Verification
REQ-042 LB addr 0x1003, rdata 0x80FF1234 -> mem_addr 0x1000, rsp_rdata 0xFFFFFF80, rsp_valid at N+2.
REQ-043 SH addr 0x2002, wdata 0x0000ABCD -> wstrb 1100, mem_wdata 0xABCD0000, rsp_err 0.
REQ-044 LW addr 0x1001: macro off -> no mem_valid, rsp_err 1 at N+1; macro on, rdata 0x44332211/0x88776655 -> rsp_rdata 0x55443322.
REQ-045 TIMEOUT_CYCLES = 4, mem_ready held 0 -> mem_valid high N+1..N+4, rsp_err 1 at N+5.
REQ-046 rst pulsed in BEAT0 with mem_ready low -> next cycle mem_valid 0, req_ready 1, no rsp_valid.
REQ-047 funct3 011 load -> no bus beat, rsp_err 1; following LBU 0x1000, rdata 0x000000F0 -> 0x000000F0.
